// File: rtl/ecall_io_sequencer.sv
// ============================================================================
// Module      : ecall_io_sequencer
// Description : Multi-cycle ecall service controller. It stalls the core, runs
//               tube/LED output, switch read, keyboard read or halt, writes a0,
//               and then releases the core for one advancing cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecall_io_sequencer #(
    parameter int               CNT_W           = 16,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ecall_req,
    input  logic [7:0]  service_code,
    input  logic [31:0] arg_data,
    input  logic        confirm_btn,
    input  logic [7:0]  switch_in,
    input  logic [31:0] keyboard_in,
    input  logic        keyboard_finish,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] tube_out,
    output logic [7:0]  led_out,
    output logic        halted
);

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_EXEC       = 3'd1;
    localparam logic [2:0] c_WAIT_REL   = 3'd2;
    localparam logic [2:0] c_WAIT_PRESS = 3'd3;
    localparam logic [2:0] c_WAIT_KBD   = 3'd4;
    localparam logic [2:0] c_WB         = 3'd5;
    localparam logic [2:0] c_RESUME     = 3'd6;
    localparam logic [2:0] c_HALT       = 3'd7;

    localparam logic [CNT_W-1:0] c_DB_LAST = DEBOUNCE_CYCLES - 1'b1;

    logic [2:0]       r_state;
    logic [7:0]       r_code;
    logic [31:0]      r_arg;
    logic [31:0]      r_wb_data;
    logic [31:0]      r_tube;
    logic [7:0]       r_led;
    logic             r_halted;
    logic [1:0]       r_btn_sync;
    logic             r_btn_db;
    logic [CNT_W-1:0] r_db_cnt;

    // Stall on the ecall cycle itself; only IDLE (no request) and RESUME let the PC move.
    assign stall    = (r_state == c_IDLE) ? ecall_req : (r_state != c_RESUME);
    assign wb_en    = (r_state == c_WB);
    assign wb_addr  = 5'd10;
    assign wb_data  = r_wb_data;
    assign tube_out = r_tube;
    assign led_out  = r_led;
    assign halted   = r_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_sync <= 2'b00;
            r_btn_db   <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_sync <= {r_btn_sync[0], confirm_btn};
            if (r_btn_sync[1] == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_btn_db <= ~r_btn_db;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_code    <= 8'd0;
            r_arg     <= 32'd0;
            r_wb_data <= 32'd0;
            r_tube    <= 32'd0;
            r_led     <= 8'd0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (ecall_req) begin
                        r_code  <= service_code;
                        r_arg   <= arg_data;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    case (r_code)
                        8'd1: begin
                            r_tube  <= r_arg;
                            r_state <= c_RESUME;
                        end
                        8'd2: begin
                            r_led   <= r_arg[7:0];
                            r_state <= c_RESUME;
                        end
                        8'd5:    r_state <= c_WAIT_REL;
                        8'd6:    r_state <= c_WAIT_KBD;
                        8'd10: begin
                            r_halted <= 1'b1;
                            r_state  <= c_HALT;
                        end
                        default: r_state <= c_RESUME;
                    endcase
                end
                // A button still held from the previous read must be let go first.
                c_WAIT_REL: begin
                    if (!r_btn_db) r_state <= c_WAIT_PRESS;
                end
                c_WAIT_PRESS: begin
                    if (r_btn_db) begin
                        r_wb_data <= {24'b0, switch_in};
                        r_state   <= c_WB;
                    end
                end
                c_WAIT_KBD: begin
                    if (keyboard_finish) begin
                        r_wb_data <= keyboard_in;
                        r_state   <= c_WB;
                    end
                end
                c_WB:     r_state <= c_RESUME;
                c_RESUME: r_state <= c_IDLE;
                c_HALT:   r_state <= c_HALT;
                default:  r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ecall_io_sequencer.sv
// ============================================================================
// Module      : tb_ecall_io_sequencer
// Description : Self-checking bench for ecall_io_sequencer (vector table for
//               output calls, scoreboard for register write-backs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ecall_io_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ecall_req;
    logic [7:0]  service_code;
    logic [31:0] arg_data;
    logic        confirm_btn;
    logic [7:0]  switch_in;
    logic [31:0] keyboard_in;
    logic        keyboard_finish;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] tube_out;
    logic [7:0]  led_out;
    logic        halted;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_pulses = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [7:0]  code;
        logic [31:0] arg;
        logic [31:0] exp_tube;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs[6];

    ecall_io_sequencer #(.CNT_W(16), .DEBOUNCE_CYCLES(16'd4)) dut (
        .clk(clk), .rst(rst), .ecall_req(ecall_req), .service_code(service_code),
        .arg_data(arg_data), .confirm_btn(confirm_btn), .switch_in(switch_in),
        .keyboard_in(keyboard_in), .keyboard_finish(keyboard_finish),
        .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .tube_out(tube_out), .led_out(led_out), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Polls for the stall-low RESUME cycle; leaves the bench inside that cycle.
    task automatic wait_resume(input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (stall === 1'b0) ok = 1'b1;
            else tick();
        end
        chk(name, {31'b0, ok}, 32'd1);
    endtask

    // Write-back scoreboard: every wb_en pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && wb_en === 1'b1) begin
            n_pulses++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got data %h with no write expected", wb_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (wb_data !== e || wb_addr !== 5'd10) begin
                    n_err++;
                    $display("FAIL wb_data: got %h addr %0d expected %h addr 10", wb_data, wb_addr, e);
                end
            end
        end
    end

    initial begin
        int p0;
        int bad;
        vecs[0] = '{8'd1,    32'h0000_1234, 32'h0000_1234, 8'h00};
        vecs[1] = '{8'd2,    32'hFFFF_FF5A, 32'h0000_1234, 8'h5A};
        vecs[2] = '{8'd3,    32'h0000_CAFE, 32'h0000_1234, 8'h5A};
        vecs[3] = '{8'd1,    32'hDEAD_BEEF, 32'hDEAD_BEEF, 8'h5A};
        vecs[4] = '{8'd2,    32'h0000_0100, 32'hDEAD_BEEF, 8'h00};
        vecs[5] = '{8'h81,   32'h1111_1111, 32'hDEAD_BEEF, 8'h00};

        rst = 1'b1; ecall_req = 1'b0; service_code = 8'd0; arg_data = 32'd0;
        confirm_btn = 1'b0; switch_in = 8'd0; keyboard_in = 32'd0; keyboard_finish = 1'b0;
        #2;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_tube", tube_out, 32'd0);
        chk("rst_led", {24'b0, led_out}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("wb_addr", {27'b0, wb_addr}, 32'd10);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Output-class calls: 3-cycle service, no write-back.
        foreach (vecs[i]) begin
            ecall_req = 1'b1; service_code = vecs[i].code; arg_data = vecs[i].arg;
            #1;
            chk("out_stall_c0", {31'b0, stall}, 32'd1);
            tick();
            service_code = 8'd0; arg_data = 32'd0;
            chk("out_stall_c1", {31'b0, stall}, 32'd1);
            tick();
            chk("out_stall_c2", {31'b0, stall}, 32'd0);
            chk("out_tube", tube_out, vecs[i].exp_tube);
            chk("out_led", {24'b0, led_out}, {24'b0, vecs[i].exp_led});
            ecall_req = 1'b0;
            tick();
            chk("out_idle_stall", {31'b0, stall}, 32'd0);
        end

        // Switch read with the button held at entry.
        confirm_btn = 1'b1; switch_in = 8'hA5;
        repeat (8) tick();
        p0 = n_pulses;
        ecall_req = 1'b1; service_code = 8'd5;
        repeat (12) tick();
        chk("sw_held_stall", {31'b0, stall}, 32'd1);
        chk("sw_held_nowb", n_pulses - p0, 32'd0);
        exp_q.push_back(32'h0000_00A5);
        confirm_btn = 1'b0;
        repeat (8) tick();
        confirm_btn = 1'b1;
        wait_resume(20, "sw_resume");
        chk("sw_pulses", n_pulses - p0, 32'd1);
        ecall_req = 1'b0;
        tick();
        chk("sw_idle_stall", {31'b0, stall}, 32'd0);

        // Bouncing button must not complete the read; a clean press must.
        p0 = n_pulses;
        ecall_req = 1'b1; service_code = 8'd5; switch_in = 8'h3C;
        tick();
        confirm_btn = 1'b0;
        repeat (8) tick();
        for (int k = 0; k < 20; k++) begin
            confirm_btn = ((k / 2) % 2 == 0);
            tick();
        end
        confirm_btn = 1'b0;
        repeat (3) tick();
        chk("bounce_nowb", n_pulses - p0, 32'd0);
        chk("bounce_stall", {31'b0, stall}, 32'd1);
        exp_q.push_back(32'h0000_003C);
        confirm_btn = 1'b1;
        wait_resume(20, "bounce_resume");
        chk("bounce_pulses", n_pulses - p0, 32'd1);
        ecall_req = 1'b0;
        tick();

        // Keyboard read.
        p0 = n_pulses; bad = 0;
        ecall_req = 1'b1; service_code = 8'd6; keyboard_in = 32'hDEAD_BEEF;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (stall !== 1'b1) bad++;
            tick();
        end
        chk("kbd_stall_held", bad, 32'd0);
        exp_q.push_back(32'hDEAD_BEEF);
        keyboard_finish = 1'b1;
        wait_resume(10, "kbd_resume");
        keyboard_finish = 1'b0;
        chk("kbd_pulses", n_pulses - p0, 32'd1);
        chk("kbd_wb_data", wb_data, 32'hDEAD_BEEF);
        ecall_req = 1'b0;
        tick();

        // Re-trigger guard: request held through RESUME restarts only from IDLE.
        ecall_req = 1'b1; service_code = 8'd1; arg_data = 32'h0000_0077;
        tick(); tick();
        chk("rt_resume_stall", {31'b0, stall}, 32'd0);
        chk("rt_tube1", tube_out, 32'h0000_0077);
        arg_data = 32'h0000_0088;
        tick();
        chk("rt_idle_restart", {31'b0, stall}, 32'd1);
        tick(); tick();
        chk("rt_resume2", {31'b0, stall}, 32'd0);
        chk("rt_tube2", tube_out, 32'h0000_0088);
        ecall_req = 1'b0;
        tick();

        // Reset in the middle of a keyboard wait drops the pending write.
        p0 = n_pulses;
        ecall_req = 1'b1; service_code = 8'd6; keyboard_in = 32'h1234_5678;
        repeat (4) tick();
        ecall_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        chk("mid_rst_tube", tube_out, 32'd0);
        tick();
        rst = 1'b0;
        keyboard_finish = 1'b1;
        repeat (3) tick();
        keyboard_finish = 1'b0;
        chk("mid_rst_nowb", n_pulses - p0, 32'd0);

        // Halt is absorbing until an asynchronous reset.
        ecall_req = 1'b1; service_code = 8'd10;
        tick(); tick();
        ecall_req = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (stall !== 1'b1 || halted !== 1'b1) bad++;
            tick();
        end
        chk("halt_hold", bad, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("halt_rst_stall", {31'b0, stall}, 32'd0);
        chk("halt_rst_halted", {31'b0, halted}, 32'd0);
        chk("halt_rst_tube", tube_out, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
